// File: rtl/btn_evt_pkg.sv
// Shared event encodings, pending-bit positions and width helper for the
// front-panel button event controller.
package btn_evt_pkg;

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_LONG    = 2'b11;

    localparam int BIT_PRESS   = 0;
    localparam int BIT_RELEASE = 1;
    localparam int BIT_LONG    = 2;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: two-flop synchroniser, tick-qualified debounce and
// long-press timer, producing one-cycle PRESS/RELEASE/LONG raise strobes.
module btn_debounce_chan
    import btn_evt_pkg::*;
#(
    parameter int STABLE_TICKS = 20,
    parameter int LONG_TICKS   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic raise_press,
    output logic raise_release,
    output logic raise_long
);

    localparam int SW = clog2_min1(STABLE_TICKS);
    localparam int HW = clog2_min1(LONG_TICKS + 1);

    logic          meta_r;
    logic          sync_r;
    logic          level_r;
    logic [SW-1:0] stab_cnt_r;
    logic [HW-1:0] hold_cnt_r;
    logic          raise_press_r;
    logic          raise_release_r;
    logic          raise_long_r;

    // Two-flop synchroniser for the raw pad input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= btn;
            sync_r <= meta_r;
        end
    end

    // Debounce: a new level needs STABLE_TICKS consecutive disagreeing ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r         <= 1'b0;
            stab_cnt_r      <= '0;
            raise_press_r   <= 1'b0;
            raise_release_r <= 1'b0;
        end else begin
            raise_press_r   <= 1'b0;
            raise_release_r <= 1'b0;
            if (tick) begin
                if (sync_r != level_r) begin
                    if (stab_cnt_r == SW'(STABLE_TICKS - 1)) begin
                        level_r         <= sync_r;
                        stab_cnt_r      <= '0;
                        raise_press_r   <= sync_r;
                        raise_release_r <= !sync_r;
                    end else begin
                        stab_cnt_r <= stab_cnt_r + 1'b1;
                    end
                end else begin
                    stab_cnt_r <= '0;
                end
            end
        end
    end

    // Long-press timer saturates at LONG_TICKS so LONG fires once per press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r   <= '0;
            raise_long_r <= 1'b0;
        end else begin
            raise_long_r <= 1'b0;
            if (tick) begin
                if (level_r) begin
                    if (hold_cnt_r != HW'(LONG_TICKS)) begin
                        hold_cnt_r <= hold_cnt_r + 1'b1;
                        if (hold_cnt_r == HW'(LONG_TICKS - 1)) begin
                            raise_long_r <= 1'b1;
                        end
                    end
                end else begin
                    hold_cnt_r <= '0;
                end
            end
        end
    end

    assign level         = level_r;
    assign raise_press   = raise_press_r;
    assign raise_release = raise_release_r;
    assign raise_long    = raise_long_r;

endmodule

// File: rtl/button_event_ctrl.sv
// Front-panel button controller: shared sample-tick prescaler, per-channel
// debounce, pending event bits and a round-robin valid/ready event port.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20,
    parameter int LONG_TICKS   = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_BTN-1:0]              button,
    output logic [N_BTN-1:0]              level,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [clog2_min1(N_BTN)-1:0]  evt_chan,
    output logic [1:0]                    evt_type,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int CW = clog2_min1(N_BTN);
    localparam int PW = clog2_min1(TICK_DIV);

    logic [PW-1:0]         presc_r;
    logic                  tick_s;
    logic [N_BTN-1:0]      raise_press_s;
    logic [N_BTN-1:0]      raise_release_s;
    logic [N_BTN-1:0]      raise_long_s;
    logic [N_BTN-1:0][2:0] raise_vec_s;
    logic [N_BTN-1:0][2:0] pending_r;
    logic [N_BTN-1:0][2:0] clear_s;
    logic                  ovf_set_s;
    logic                  load_s;
    logic                  found_s;
    logic [CW-1:0]         cand_s;
    logic [CW-1:0]         sel_chan_s;
    logic [1:0]            sel_type_s;
    logic [2:0]            sel_mask_s;
    int                    idx_s;
    logic [CW-1:0]         rr_ptr_r;
    logic                  evt_valid_r;
    logic [CW-1:0]         evt_chan_r;
    logic [1:0]            evt_type_r;
    logic                  overflow_r;

    assign tick_s = (presc_r == PW'(TICK_DIV - 1));
    assign load_s = !evt_valid_r || evt_ready;

    // Free-running sample-tick prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + 1'b1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick_s),
            .btn           (button[g]),
            .level         (level[g]),
            .raise_press   (raise_press_s[g]),
            .raise_release (raise_release_s[g]),
            .raise_long    (raise_long_s[g])
        );
    end

    // Round-robin scan from the channel after the last one served
    always_comb begin
        found_s    = 1'b0;
        cand_s     = '0;
        sel_chan_s = '0;
        sel_type_s = EVT_NONE;
        sel_mask_s = 3'b000;
        idx_s      = 0;
        for (int i = 1; i <= N_BTN; i++) begin
            idx_s = int'(rr_ptr_r) + i;
            if (idx_s >= N_BTN) begin
                idx_s = idx_s - N_BTN;
            end else begin
                idx_s = idx_s;
            end
            cand_s = CW'(idx_s);
            if (!found_s && (pending_r[cand_s] != 3'b000)) begin
                found_s    = 1'b1;
                sel_chan_s = cand_s;
                if (pending_r[cand_s][BIT_PRESS]) begin
                    sel_type_s = EVT_PRESS;
                    sel_mask_s = 3'b001;
                end else if (pending_r[cand_s][BIT_LONG]) begin
                    sel_type_s = EVT_LONG;
                    sel_mask_s = 3'b100;
                end else begin
                    sel_type_s = EVT_RELEASE;
                    sel_mask_s = 3'b010;
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    // Per-channel raise vector and the bit consumed by this cycle's load
    always_comb begin
        raise_vec_s = '0;
        clear_s     = '0;
        for (int c = 0; c < N_BTN; c++) begin
            raise_vec_s[c] = {raise_long_s[c], raise_release_s[c], raise_press_s[c]};
            if (load_s && found_s && (sel_chan_s == CW'(c))) begin
                clear_s[c] = sel_mask_s;
            end else begin
                clear_s[c] = 3'b000;
            end
        end
    end

    // A raise only overflows if the bit survives this cycle's load
    assign ovf_set_s = |(raise_vec_s & pending_r & ~clear_s);

    // Pending event bits and sticky overflow (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            pending_r <= (pending_r & ~clear_s) | raise_vec_s;
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Output register: holds chan/type while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_r <= 1'b0;
            evt_chan_r  <= '0;
            evt_type_r  <= EVT_NONE;
            rr_ptr_r    <= '0;
        end else if (load_s) begin
            if (found_s) begin
                evt_valid_r <= 1'b1;
                evt_chan_r  <= sel_chan_s;
                evt_type_r  <= sel_type_s;
                rr_ptr_r    <= sel_chan_s;
            end else begin
                evt_valid_r <= 1'b0;
            end
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_chan  = evt_chan_r;
    assign evt_type  = evt_type_r;
    assign overflow  = overflow_r;

endmodule
